// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular-arithmetic datapath.
// Holds the default operand width, the NIST P-192 prime, the
// Montgomery multiplier FSM state type and the iteration counter width.
package mod_arith_pkg;

  localparam int N = 192;

  localparam logic [N-1:0] P192 =
    192'hfffffffffffffffffffffffffffffffeffffffffffffffff;

  // Wide enough to hold any iteration index 0..N.
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mont_state_t;

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration, purely combinational.
//   s      in   N+2  running accumulator (s < 2m)
//   y      in   N    multiplier
//   m      in   N    odd modulus
//   x_bit  in   1    current multiplicand bit
//   s_next out  N+2  (s + x_bit*y [+ m if odd]) / 2
module mont_step
  import mod_arith_pkg::*;
#(
  parameter int W = N
) (
  input  logic [W+1:0] s,
  input  logic [W-1:0] y,
  input  logic [W-1:0] m,
  input  logic         x_bit,
  output logic [W+1:0] s_next
);

  logic [W+1:0] t_add;
  logic [W+1:0] t_odd;

  // With s < 2m and y < m, t_add < 3m and t_odd < 4m, both of which fit in
  // W+2 bits. Adding the odd modulus to an odd sum makes it even, so the
  // shift below is an exact division by two.
  always_comb begin
    t_add  = s + (x_bit ? {2'b00, y} : '0);
    t_odd  = t_add[0] ? (t_add + {2'b00, m}) : t_add;
    s_next = t_odd >> 1;
  end

endmodule

// File: rtl/mod_mul_mont.sv
// Sequential radix-2 Montgomery modular multiplier.
// Computes z = x * y * 2^-N mod m, one multiplicand bit per clock.
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous reset, active HIGH despite its name
//   x      in   N  multiplicand (x < m)
//   y      in   N  multiplier   (y < m)
//   start  in   1  launch on a 0->1 transition while IDLE or DONE
//   z      out  N  fully reduced result (z < m)
//   done   out  1  high while z holds a valid result
// done rises N+1 clock edges after the launch edge.
module mod_mul_mont
  import mod_arith_pkg::*;
#(
  parameter int                W = N,
  parameter logic [W-1:0]      m = P192
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         start,
  output logic [W-1:0] z,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  mont_state_t  state;
  mont_state_t  state_next;
  logic         start_q;
  logic         launch;
  logic         last_iter;
  logic [W-1:0] x_sr;
  logic [W-1:0] y_r;
  logic [W+1:0] s;
  logic [W+1:0] s_next;
  logic [CW-1:0] iter;

  // Edges seen while CALC or FIX is running are deliberately dropped;
  // a held-high start cannot relaunch because start_q stays high.
  assign launch    = start && !start_q && ((state == IDLE) || (state == DONE));
  assign last_iter = (iter == CW'(W - 1));

  mont_step #(.W(W)) u_step (
    .s      (s),
    .y      (y_r),
    .m      (m),
    .x_bit  (x_sr[0]),
    .s_next (s_next)
  );

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE/DONE wait for a launch, CALC runs W
  // iterations, FIX takes a single cycle for the final subtraction.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (launch) state_next = CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (launch) state_next = CALC;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers. Operands are captured at launch so the caller
  // may change x and y immediately afterwards.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      start_q <= 1'b0;
      x_sr    <= '0;
      y_r     <= '0;
      s       <= '0;
      iter    <= '0;
      z       <= '0;
      done    <= 1'b0;
    end else begin
      start_q <= start;
      if (launch) begin
        x_sr <= x;
        y_r  <= y;
        s    <= '0;
        iter <= '0;
        done <= 1'b0;
      end else begin
        case (state)
          CALC: begin
            s    <= s_next;
            x_sr <= x_sr >> 1;
            iter <= iter + 1'b1;
          end
          FIX: begin
            // s < 2m, so s - m fits in W bits and the low W bits suffice.
            if (s >= {2'b00, m}) begin
              z <= s[W-1:0] - m;
            end else begin
              z <= s[W-1:0];
            end
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod_mul_mont.sv
// Self-checking bench for mod_mul_mont (N=192, P-192 modulus).
// Reference: z = x*y*R^-1 mod m using wide integer multiply and modulo,
// with R^-1 derived as (1/2)^192 mod m.
module tb_mod_mul_mont;

  localparam logic [191:0] M =
    192'hfffffffffffffffffffffffffffffffeffffffffffffffff;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [191:0] x;
  logic [191:0] y;
  logic         start;
  logic [191:0] z;
  logic         done;

  int errors = 0;
  int checks = 0;
  logic [191:0] rinv;
  logic         done_after_launch;

  mod_mul_mont dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y),
    .start (start),
    .z     (z),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Plain (a*b) mod M with double-width arithmetic.
  function automatic logic [191:0] mulmod(input logic [191:0] a, input logic [191:0] b);
    logic [383:0] p;
    p = {192'd0, a} * {192'd0, b};
    p = p % {192'd0, M};
    return p[191:0];
  endfunction

  function automatic logic [191:0] mont_ref(input logic [191:0] a, input logic [191:0] b);
    return mulmod(mulmod(a, b), rinv);
  endfunction

  function automatic logic [191:0] rand_below_m();
    logic [191:0] v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return v % M;
  endfunction

  task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  // Launches one operation and waits (bounded) for done. Inputs are
  // scrambled right after the launch edge; optionally start is held high
  // or re-pulsed at iteration toggle_at.
  task automatic applyStimulus(input logic [191:0] xa, input logic [191:0] ya,
                               input bit hold, input int toggle_at, output int cyc);
    @(negedge clk);
    x = xa;
    y = ya;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done_after_launch = done;
    if (!hold) start = 1'b0;
    x = ~xa;
    y = ~ya;
    cyc = 0;
    while (!done && cyc < 400) begin
      if (toggle_at != 0 && cyc == toggle_at) start = 1'b1;
      else if (!hold) start = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!hold) start = 1'b0;
  endtask

  initial begin
    logic [191:0] inv2;
    logic [191:0] xa;
    logic [191:0] ya;
    logic [191:0] zexp;
    int cyc;
    int bad;

    inv2 = (M + 192'd1) >> 1;
    rinv = 192'd1;
    repeat (192) rinv = mulmod(rinv, inv2);

    rst_n = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_z", z, 192'd0);
    checkOutput("reset_done", {191'd0, done}, 192'd1 - 192'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Directed vectors with literal expectations.
    applyStimulus(192'hf7, 192'h0a, 1'b0, 0, cyc);
    checkOutput("f7x0a_latency", 192'(cyc), 192'd193);
    checkOutput("f7x0a_z", z, 192'h00000000000009A5FFFFFFFFFFFFF65A0000000000000000);
    checkOutput("f7x0a_done", {191'd0, done}, 192'd1);

    applyStimulus(192'd1, 192'd1, 1'b0, 0, cyc);
    checkOutput("launch_drops_done", {191'd0, done_after_launch}, 192'd0);
    checkOutput("one_x_one_z", z, 192'h0000000000000000FFFFFFFFFFFFFFFF0000000000000000);

    applyStimulus(192'h10000000000000001, 192'd5, 1'b0, 0, cyc);
    checkOutput("rmodm_x_5", z, 192'd5);

    applyStimulus(192'd0, 192'h1234, 1'b0, 0, cyc);
    checkOutput("zero_x", z, 192'd0);

    xa = rand_below_m();
    applyStimulus(xa, 192'd0, 1'b0, 0, cyc);
    checkOutput("zero_y", z, 192'd0);

    xa = M - 192'd1;
    ya = M - 192'd1;
    applyStimulus(xa, ya, 1'b0, 0, cyc);
    checkOutput("max_operands", z, mont_ref(xa, ya));

    // Random operands against the reference model.
    for (int k = 0; k < 8; k++) begin
      xa = rand_below_m();
      ya = rand_below_m();
      applyStimulus(xa, ya, 1'b0, 0, cyc);
      checkOutput($sformatf("rand%0d_latency", k), 192'(cyc), 192'd193);
      checkOutput($sformatf("rand%0d_z", k), z, mont_ref(xa, ya));
    end

    // start held high: one operation, then a stable result.
    xa = rand_below_m();
    ya = rand_below_m();
    zexp = mont_ref(xa, ya);
    applyStimulus(xa, ya, 1'b1, 0, cyc);
    checkOutput("hold_latency", 192'(cyc), 192'd193);
    checkOutput("hold_z", z, zexp);
    bad = 0;
    repeat (2800) begin
      @(negedge clk);
      if (done !== 1'b1 || z !== zexp) bad++;
    end
    checkOutput("hold_stable", 192'(bad), 192'd0);
    start = 1'b0;
    @(negedge clk);

    // Edge during CALC is ignored; then a relaunch after done.
    xa = rand_below_m();
    ya = rand_below_m();
    applyStimulus(xa, ya, 1'b0, 50, cyc);
    checkOutput("midcalc_latency", 192'(cyc), 192'd193);
    checkOutput("midcalc_z", z, mont_ref(xa, ya));
    xa = rand_below_m();
    ya = rand_below_m();
    applyStimulus(xa, ya, 1'b0, 0, cyc);
    checkOutput("relaunch_drop", {191'd0, done_after_launch}, 192'd0);
    checkOutput("relaunch_z", z, mont_ref(xa, ya));

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    x = rand_below_m();
    y = rand_below_m();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("abort_z", z, 192'd0);
    checkOutput("abort_done", {191'd0, done}, 192'd0);
    #1 rst_n = 1'b0;
    bad = 0;
    repeat (250) begin
      @(negedge clk);
      if (done !== 1'b0 || z !== 192'd0) bad++;
    end
    checkOutput("abort_no_partial", 192'(bad), 192'd0);
    xa = rand_below_m();
    ya = rand_below_m();
    applyStimulus(xa, ya, 1'b0, 0, cyc);
    checkOutput("after_abort_latency", 192'(cyc), 192'd193);
    checkOutput("after_abort_z", z, mont_ref(xa, ya));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
